// File: rtl/layer_three_dense.sv
// layer_three_dense: binary FC classifier stage, XNOR-popcount per class
// over 28-bit chunks, then strict argmax over the class scores.
//
// Ports:
//   clk        - system clock, rising edge
//   rst        - synchronous reset, active-high
//   state      - top-level FSM state; runs only while == S_LAYER_3
//   features   - 196-bit layer-two feature map, held while running
//   weights    - class c row at bits [c*N_IN +: N_IN]
//   digit      - argmax class, valid when done=1
//   best_score - popcount score of the winning class
//   done       - classification complete
module layer_three_dense #(
  parameter int         N_IN      = 196,
  parameter int         N_CLASS   = 10,
  parameter int         CHUNK_W   = 28,
  parameter int         N_CHUNK   = 7,
  parameter logic [2:0] S_LAYER_3 = 3'b100
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [2:0]                state,
  input  logic [N_IN-1:0]           features,
  input  logic [N_IN*N_CLASS-1:0]   weights,
  output logic [3:0]                digit,
  output logic [7:0]                best_score,
  output logic                      done
);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    COMPARE,
    DONE
  } st_t;

  localparam logic [2:0] LAST_CHK = 3'(N_CHUNK - 1);
  localparam logic [3:0] LAST_CLS = 4'(N_CLASS - 1);

  st_t        st_q, st_d;
  logic [3:0] cls_q, cls_d;
  logic [2:0] chk_q, chk_d;
  logic [7:0] acc_q, acc_d;
  logic [3:0] dig_q, dig_d;
  logic [7:0] best_q, best_d;
  logic       done_q, done_d;

  logic               run;
  logic [7:0]         f_off;
  logic [10:0]        w_off;
  logic [CHUNK_W-1:0] f_chunk;
  logic [CHUNK_W-1:0] w_chunk;
  logic [CHUNK_W-1:0] match;
  logic [4:0]         pc;

  assign run = (state == S_LAYER_3);

  // Chunk select and popcount of the XNOR agreement bits.
  always_comb begin
    f_off   = 8'(chk_q) * 8'(CHUNK_W);
    w_off   = 11'(cls_q) * 11'(N_IN) + 11'(f_off);
    f_chunk = features[f_off +: CHUNK_W];
    w_chunk = weights[w_off +: CHUNK_W];
    match   = ~(f_chunk ^ w_chunk);
    pc      = '0;
    for (int i = 0; i < CHUNK_W; i++) begin
      pc = pc + 5'(match[i]);
    end
  end

  always_comb begin
    st_d   = st_q;
    cls_d  = cls_q;
    chk_d  = chk_q;
    acc_d  = acc_q;
    dig_d  = dig_q;
    best_d = best_q;
    done_d = 1'b0;
    unique case (st_q)
      IDLE: begin
        cls_d = '0;
        chk_d = '0;
        acc_d = '0;
        if (run) begin
          st_d = ACCUM;
        end
      end
      ACCUM: begin
        if (!run) begin
          st_d  = IDLE;
          cls_d = '0;
          chk_d = '0;
          acc_d = '0;
        end else begin
          acc_d = acc_q + 8'(pc);
          if (chk_q == LAST_CHK) begin
            chk_d = '0;
            st_d  = COMPARE;
          end else begin
            chk_d = chk_q + 3'd1;
          end
        end
      end
      COMPARE: begin
        if (!run) begin
          st_d  = IDLE;
          cls_d = '0;
          chk_d = '0;
          acc_d = '0;
        end else begin
          // Strict compare: ties keep the lower class index.
          if (cls_q == '0 || acc_q > best_q) begin
            best_d = acc_q;
            dig_d  = cls_q;
          end
          if (cls_q == LAST_CLS) begin
            st_d = DONE;
          end else begin
            cls_d = cls_q + 4'd1;
            chk_d = '0;
            acc_d = '0;
            st_d  = ACCUM;
          end
        end
      end
      DONE: begin
        if (run) begin
          done_d = 1'b1;
        end else begin
          st_d = IDLE;
        end
      end
      default: begin
        st_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q   <= IDLE;
      cls_q  <= '0;
      chk_q  <= '0;
      acc_q  <= '0;
      dig_q  <= '0;
      best_q <= '0;
      done_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      cls_q  <= cls_d;
      chk_q  <= chk_d;
      acc_q  <= acc_d;
      dig_q  <= dig_d;
      best_q <= best_d;
      done_q <= done_d;
    end
  end

  assign digit      = dig_q;
  assign best_score = best_q;
  assign done       = done_q;

endmodule

// File: tb/tb_layer_three_dense.sv
// tb_layer_three_dense: randomized and directed checks of the
// binary FC classifier against a plain-arithmetic argmax model.
module tb_layer_three_dense;

  localparam logic [2:0] S3 = 3'b100;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [2:0]    state = 3'b000;
  logic [195:0]  f = '0;
  logic [1959:0] w = '0;
  logic [3:0]    digit;
  logic [7:0]    best_score;
  logic          done;

  int errors = 0;
  int checks = 0;

  layer_three_dense dut (
    .clk        (clk),
    .rst        (rst),
    .state      (state),
    .features   (f),
    .weights    (w),
    .digit      (digit),
    .best_score (best_score),
    .done       (done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic ref_model(output int dig, output int best);
    int s;
    dig = 0;
    best = 0;
    for (int c = 0; c < 10; c++) begin
      s = 0;
      for (int i = 0; i < 196; i++)
        if (f[i] == w[c*196+i]) s++;
      if (c == 0 || s > best) begin
        best = s;
        dig = c;
      end
    end
  endtask

  task automatic rand_data();
    for (int i = 0; i < 196; i++) f[i] = 1'($urandom_range(0, 1));
    for (int i = 0; i < 1960; i++) w[i] = 1'($urandom_range(0, 1));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    state = 3'b000;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // n = index of the first edge after which done reads 1 (edge 0 is
  // the first edge that sees state==S3), or -1 on timeout.
  task automatic run_wait(output int n);
    @(negedge clk);
    state = S3;
    n = -1;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (done === 1'b1) begin
        n = k;
        break;
      end
    end
  endtask

  task automatic release_state();
    @(negedge clk);
    state = 3'b000;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (digit !== 4'd0) begin
      errors++;
      $display("FAIL reset_digit got=%0d want=0", digit);
    end
    checks++;
    if (best_score !== 8'd0) begin
      errors++;
      $display("FAIL reset_best got=%0d want=0", best_score);
    end
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL reset_done got=%0b want=0", done);
    end
  endtask

  task automatic test_zero_features();
    int n;
    f = '0;
    w = '1;
    w[3*196 +: 196] = '0;
    run_wait(n);
    checks++;
    if (n != 81) begin
      errors++;
      $display("FAIL zero_latency got=%0d want=81", n);
    end
    checks++;
    if (digit !== 4'd3) begin
      errors++;
      $display("FAIL zero_digit got=%0d want=3", digit);
    end
    checks++;
    if (best_score !== 8'd196) begin
      errors++;
      $display("FAIL zero_best got=%0d want=196", best_score);
    end
    release_state();
    checks++;
    if (done !== 1'b0 || digit !== 4'd3 || best_score !== 8'd196) begin
      errors++;
      $display("FAIL zero_hold got=%0b/%0d/%0d want=0/3/196",
               done, digit, best_score);
    end
  endtask

  task automatic test_ties();
    logic [195:0] row;
    int exp_best;
    int n;
    for (int i = 0; i < 196; i++) row[i] = 1'($urandom_range(0, 1));
    for (int i = 0; i < 196; i++) f[i] = 1'($urandom_range(0, 1));
    for (int c = 0; c < 10; c++) w[c*196 +: 196] = row;
    exp_best = 0;
    for (int i = 0; i < 196; i++)
      if (f[i] == row[i]) exp_best++;
    run_wait(n);
    checks++;
    if (n != 81 || digit !== 4'd0) begin
      errors++;
      $display("FAIL ties_digit got=%0d (lat %0d) want=0 (lat 81)",
               digit, n);
    end
    checks++;
    if (best_score !== 8'(exp_best)) begin
      errors++;
      $display("FAIL ties_best got=%0d want=%0d", best_score, exp_best);
    end
    release_state();
  endtask

  task automatic test_alternating();
    int n;
    for (int i = 0; i < 196; i++) f[i] = 1'(i % 2);
    for (int c = 0; c < 9; c++) w[c*196 +: 196] = ~f;
    w[9*196 +: 196] = f;
    run_wait(n);
    checks++;
    if (n != 81 || digit !== 4'd9) begin
      errors++;
      $display("FAIL alt_digit got=%0d (lat %0d) want=9 (lat 81)",
               digit, n);
    end
    checks++;
    if (best_score !== 8'd196) begin
      errors++;
      $display("FAIL alt_best got=%0d want=196", best_score);
    end
    release_state();
  endtask

  task automatic test_chunk_boundary();
    int n;
    for (int v = 0; v < 2; v++) begin
      f = '0;
      w = '1;
      for (int r = 5; r <= 6; r++)
        for (int i = 0; i < 100; i++) w[r*196+i] = 1'b0;
      w[5*196+195] = 1'(v);
      w[6*196+195] = 1'(1 - v);
      run_wait(n);
      checks++;
      if (n != 81 || digit !== 4'(5 + v)) begin
        errors++;
        $display("FAIL chunk_digit v=%0d got=%0d want=%0d",
                 v, digit, 5 + v);
      end
      checks++;
      if (best_score !== 8'd101) begin
        errors++;
        $display("FAIL chunk_best v=%0d got=%0d want=101",
                 v, best_score);
      end
      release_state();
    end
  endtask

  task automatic test_abort();
    int ed, eb, n;
    bit seen;
    rand_data();
    ref_model(ed, eb);
    @(negedge clk);
    state = S3;
    repeat (30) @(posedge clk);
    @(negedge clk);
    state = 3'b000;
    seen = 1'b0;
    for (int k = 0; k < 90; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (done !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL abort_done got=1 want=0");
    end
    run_wait(n);
    checks++;
    if (n != 81) begin
      errors++;
      $display("FAIL abort_restart_lat got=%0d want=81", n);
    end
    checks++;
    if (digit !== 4'(ed) || best_score !== 8'(eb)) begin
      errors++;
      $display("FAIL abort_result got=%0d/%0d want=%0d/%0d",
               digit, best_score, ed, eb);
    end
    release_state();
  endtask

  task automatic test_reset_midrun();
    int n;
    f = '0;
    w = '1;
    w[3*196 +: 196] = '0;
    @(negedge clk);
    state = S3;
    repeat (51) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    state = 3'b000;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (digit !== 4'd0 || best_score !== 8'd0 || done !== 1'b0) begin
      errors++;
      $display("FAIL midreset got=%0d/%0d/%0b want=0/0/0",
               digit, best_score, done);
    end
    run_wait(n);
    checks++;
    if (n != 81 || digit !== 4'd3 || best_score !== 8'd196) begin
      errors++;
      $display("FAIL midreset_rerun got=%0d/%0d lat %0d want=3/196 lat 81",
               digit, best_score, n);
    end
    release_state();
  endtask

  task automatic test_random();
    int ed, eb, n;
    for (int t = 0; t < 5; t++) begin
      rand_data();
      ref_model(ed, eb);
      run_wait(n);
      checks++;
      if (n != 81) begin
        errors++;
        $display("FAIL rand_lat t=%0d got=%0d want=81", t, n);
      end
      checks++;
      if (digit !== 4'(ed) || best_score !== 8'(eb)) begin
        errors++;
        $display("FAIL rand_result t=%0d got=%0d/%0d want=%0d/%0d",
                 t, digit, best_score, ed, eb);
      end
      release_state();
    end
  endtask

  initial begin
    test_reset();
    test_zero_features();
    test_ties();
    test_alternating();
    test_chunk_boundary();
    test_abort();
    test_reset_midrun();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
